// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive/transmit path: protocol constants,
// sideband field positions and the receive parser state encoding.
package udp_pkg;

  localparam logic [7:0]  UDP_PROTO     = 8'd17;
  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

  // 56-bit IP sideband: {len[55:40], flag[39:37], proto[36:29], offset[28:16], id[15:0]}
  localparam int IPU_LEN_HI   = 55;
  localparam int IPU_LEN_LO   = 40;
  localparam int IPU_PROTO_HI = 36;
  localparam int IPU_PROTO_LO = 29;

  // 32-bit user sideband: {src port[31:16], payload byte length[15:0]}
  localparam int UU_SRC_HI = 31;
  localparam int UU_SRC_LO = 16;
  localparam int UU_LEN_HI = 15;
  localparam int UU_LEN_LO = 0;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_USER_W = 32;
  localparam int AXIS_KEEP_W = 8;
  localparam int AXIS_SLICE_W = AXIS_DATA_W + AXIS_USER_W + AXIS_KEEP_W + 1;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } udp_state_e;

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single registered valid/ready stage; accepts a new beat whenever the
// register is empty or being drained in the same cycle.
module axis_reg_slice #(
  parameter int W = 105
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign s_ready_o = !valid_q || m_ready_i;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (s_ready_o) begin
      valid_q <= s_valid_i;
      if (s_valid_i) begin
        data_q <= s_data_i;
      end
    end
  end

endmodule

// File: rtl/udp_rx.sv
// UDP receive layer: strips the 8-byte header, filters on protocol and
// destination port, and forwards the payload with {src port, length} metadata.
module udp_rx
  import udp_pkg::*;
#(
  parameter logic [15:0] P_LOCAL_UDP_PORT = 16'h0808,
  parameter int          P_CHECK_PORT     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_dymanic_local_port,
  input  logic        i_dymanic_local_valid,
  input  logic [63:0] s_axis_ip_data,
  input  logic [55:0] s_axis_ip_user,
  input  logic [7:0]  s_axis_ip_keep,
  input  logic        s_axis_ip_last,
  input  logic        s_axis_ip_valid,
  output logic        s_axis_ip_ready,
  output logic [63:0] m_axis_user_data,
  output logic [31:0] m_axis_user_user,
  output logic [7:0]  m_axis_user_keep,
  output logic        m_axis_user_last,
  output logic        m_axis_user_valid,
  input  logic        m_axis_user_ready,
  output logic        o_drop_pulse,
  output logic        o_len_err
);

  udp_state_e  state_q;
  logic [15:0] local_port_q;
  logic [31:0] user_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        drop_q;
  logic        len_err_q;

  logic        slice_ready;
  logic        slice_valid;
  logic [AXIS_SLICE_W-1:0] slice_in;
  logic [AXIS_SLICE_W-1:0] slice_out;

  logic [15:0] hdr_src;
  logic [15:0] hdr_dst;
  logic [15:0] hdr_len;
  logic [15:0] ip_len;
  logic [7:0]  ip_proto;
  logic        hdr_drop;
  logic [15:0] pay_len;
  logic [15:0] rx_bytes;
  logic        acc;
  logic        unused_ip_user;

  assign hdr_src  = s_axis_ip_data[63:48];
  assign hdr_dst  = s_axis_ip_data[47:32];
  assign hdr_len  = s_axis_ip_data[31:16];
  assign ip_len   = s_axis_ip_user[IPU_LEN_HI:IPU_LEN_LO];
  assign ip_proto = s_axis_ip_user[IPU_PROTO_HI:IPU_PROTO_LO];
  assign unused_ip_user = ^{s_axis_ip_user[IPU_LEN_LO-1:IPU_PROTO_HI+1],
                            s_axis_ip_user[IPU_PROTO_LO-1:0]};

  assign hdr_drop = (ip_proto != UDP_PROTO)
                 || ((P_CHECK_PORT != 0) && (hdr_dst != local_port_q))
                 || (hdr_len < UDP_HDR_BYTES)
                 || (hdr_len > ip_len);
  assign pay_len  = (hdr_len >= UDP_HDR_BYTES) ? (hdr_len - UDP_HDR_BYTES) : 16'd0;

  // Byte count uses the beats already seen plus the partial final beat.
  assign rx_bytes = {cnt_q[12:0], 3'b000} + {12'd0, keep_bytes(s_axis_ip_keep)};
  assign cnt_d    = cnt_q + 16'd1;

  // DROP swallows beats regardless of the output stage.
  assign s_axis_ip_ready = (state_q == DROP) || slice_ready;
  assign acc             = s_axis_ip_valid && s_axis_ip_ready;

  assign slice_valid = acc && (state_q == PAYLOAD);
  assign slice_in    = {s_axis_ip_data, user_q, s_axis_ip_keep, s_axis_ip_last};

  axis_reg_slice #(.W(AXIS_SLICE_W)) u_out_slice (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .s_data_i  (slice_in),
    .s_valid_i (slice_valid),
    .s_ready_o (slice_ready),
    .m_data_o  (slice_out),
    .m_valid_o (m_axis_user_valid),
    .m_ready_i (m_axis_user_ready)
  );

  assign {m_axis_user_data, m_axis_user_user, m_axis_user_keep, m_axis_user_last} = slice_out;
  assign o_drop_pulse = drop_q;
  assign o_len_err    = len_err_q;

  // Compared only on header beats, so a load never disturbs a packet in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      local_port_q <= P_LOCAL_UDP_PORT;
    end else if (i_dymanic_local_valid) begin
      local_port_q <= i_dymanic_local_port;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= HEADER;
      user_q    <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      drop_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (acc) begin
        case (state_q)
          HEADER: begin
            if (hdr_drop) begin
              drop_q  <= 1'b1;
              state_q <= s_axis_ip_last ? HEADER : DROP;
            end else begin
              user_q <= {hdr_src, pay_len};
              if (s_axis_ip_last) begin
                len_err_q <= (hdr_len != UDP_HDR_BYTES);
              end else begin
                state_q <= PAYLOAD;
                cnt_q   <= '0;
              end
            end
          end
          PAYLOAD: begin
            cnt_q <= cnt_d;
            if (s_axis_ip_last) begin
              state_q   <= HEADER;
              len_err_q <= (rx_bytes != user_q[UU_LEN_HI:UU_LEN_LO]);
            end
          end
          DROP: begin
            if (s_axis_ip_last) begin
              state_q <= HEADER;
            end
          end
          default: state_q <= HEADER;
        endcase
      end
    end
  end

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Receive-side UDP layer of the 10G stack. Consumes 64-bit AXI-Stream IP payload beats delivered by the IP receive layer.
- Parses and strips the 8-byte UDP header, filters on protocol and destination port, and forwards the UDP payload to the user AXI-Stream interface with packet metadata.
- Discarded packets are fully consumed and never appear on the user side.

Parameters:
P_LOCAL_UDP_PORT, 16'h0808, reset value of the accepted destination port.
P_CHECK_PORT, 1, 1 = drop packets whose dst port differs from the local port; 0 = accept any port.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_dymanic_local_port  in  16  new local port value
i_dymanic_local_valid  in  1  load strobe for i_dymanic_local_port
s_axis_ip_data  in  64  IP payload beat; byte 0 of the packet is in [63:56]
s_axis_ip_user  in  56  {16 ip payload len, 3 flag, 8 protocol, 13 offset, 16 ID}; stable for the whole packet
s_axis_ip_keep  in  8  byte enables; bit7 = [63:56]; contiguous from bit7 downward
s_axis_ip_last  in  1  last beat of the packet
s_axis_ip_valid  in  1  beat valid
s_axis_ip_ready  out  1  beat accepted when valid&ready
m_axis_user_data  out  64  UDP payload beat
m_axis_user_user  out  32  {16 src port, 16 payload byte length}
m_axis_user_keep  out  8  byte enables, same convention as input
m_axis_user_last  out  1  last payload beat
m_axis_user_valid  out  1  payload valid
m_axis_user_ready  in  1  downstream ready
o_drop_pulse  out  1  one-cycle pulse per discarded packet
o_len_err  out  1  one-cycle pulse at packet end on length mismatch

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk. On reset: local port = P_LOCAL_UDP_PORT; state = HEADER; all m_axis_user_* outputs = 0 (keep = 0); o_drop_pulse = 0; o_len_err = 0. A reset mid-packet aborts the packet; the remainder of that packet is parsed as a new header.
- Local port: when i_dymanic_local_valid = 1, load i_dymanic_local_port. The new value takes effect from the next HEADER beat; a packet already in progress is unaffected.
- Output stage: single registered stage.
  - s_axis_ip_ready = !m_axis_user_valid || m_axis_user_ready.
  - The output register holds its value while valid & !ready; no beat is lost or duplicated.
- Header beat fields (first accepted beat): src = [63:48], dst = [47:32], len = [31:16], checksum = [15:0] (ignored).
- HEADER state, on the accepted first beat. Compute drop = any of:
  - protocol != 8'd17
  - P_CHECK_PORT and dst != local port
  - len < 8
  - len > ip payload len
- If drop:
  - pulse o_drop_pulse; go to DROP, or stay in HEADER if last = 1.
- If no drop:
  - latch user = {src, len-8};
  - if last = 1 (header-only packet): emit nothing; if len != 8, pulse o_len_err; stay in HEADER;
  - otherwise go to PAYLOAD and clear the beat counter.
  - The header beat is never forwarded.
- PAYLOAD state, on each accepted beat:
  - forward data and keep; m_axis_user_user = latched value; increment the 16-bit beat counter.
  - On last: set m_axis_user_last = 1 and return to HEADER.
  - Length check at last: bytes = 8*count + popcount(keep). If bytes != len-8, pulse o_len_err (payload still forwarded).
  - Latency: input beat to m_axis_user_valid is 1 cycle.
- DROP state: ready is held at 1 (independent of the output stage); consume beats until last, then return to HEADER. Nothing is emitted.
- Back-to-back packets: the next header may arrive the cycle after last, with zero bubble required.
- Simultaneous events:
  - last together with a local-port load: the load applies to the next packet.
  - m_axis_user_ready low during DROP has no effect on dropping.
- All length arithmetic is 16-bit unsigned; len-8 is computed only when len >= 8.

Decomposition:
- Shared package udp_pkg:
  - UDP_PROTO = 8'd17, UDP_HDR_BYTES = 8;
  - user-field bit positions for the 56-bit IP user field and the 32-bit user field;
  - state enum {HEADER, PAYLOAD, DROP}.
- One natural sub-module: axis_reg_slice (64+32+8+1 payload, valid/ready register stage), reusable by the TX path.

Test Plan:
- Accept: dst = 0x0808, len = 20, protocol 17, 3 beats (keep ff, ff, f0) -> 2 output beats; user = {src, 16'd12}; second beat keep f0, last = 1; o_len_err = 0.
- Port mismatch: dst = 0x1234, local port 0x0808, 4 beats -> no output valid; o_drop_pulse = 1 once; ready held at 1 for all 4 beats.
- Dynamic port: load 0x1234 via i_dymanic_local_valid, resend the same packet -> accepted, payload forwarded.
- Backpressure: m_axis_user_ready toggling 1/0 every cycle on a 9-beat packet -> all 8 payload beats appear in order, no duplicates; s_axis_ip_ready follows the ready formula.
- Length error / protocol: len = 32 but last arrives after 2 payload beats keep ff, ff -> o_len_err pulse; protocol = 6 -> dropped.
- Back-to-back plus reset: two packets with no gap -> both forwarded; i_rst asserted mid-payload -> outputs zero immediately, next packet parsed correctly.
